// File: rtl/demux1_7_reg.sv
// demux1_7_reg
//   Registered 1-to-7 data distributor. One value plus a 3-bit destination
//   index is accepted on a valid/ready input channel, held in a single-entry
//   output register, and offered to exactly one of seven destinations until
//   that destination accepts it. Selector 3'b111 is illegal: such a value is
//   accepted and dropped, and the sticky err_sel flag is raised.
//
//   Optional feature macro: DEMUX_DROP_COUNT_EN adds the drop_count port, a
//   saturating 8-bit count of illegal-selector drops.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   in_valid    producer has a value on data_in/selector
//   in_ready    input accepted this cycle (combinational on out_ready)
//   selector    destination index 0..6
//   data_in     value to deliver
//   out_valid   one-hot offer, bit i targets destination i
//   out_ready   per-destination accept
//   data_out    held value, shared by all destinations
//   err_sel     sticky illegal-selector flag
//   drop_count  saturating illegal-drop count (DEMUX_DROP_COUNT_EN only)
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | nothing held, out_valid = 0, in_ready = 1
// FULL  | value held, out_valid = 1 << sel_q, in_ready follows
//       | the held destination's out_ready

module demux1_7_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            selector,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [6:0]            out_valid,
  input  logic [6:0]            out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err_sel
`ifdef DEMUX_DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] sel_q;
  logic [7:0] ready_ext;
  logic       held_ready;
  logic       in_xfer;
  logic       out_xfer;
  logic       legal_in;
  logic       illegal_in;

  // Padding to 8 bits keeps the held-index lookup in range for every
  // 3-bit value, even though sel_q never holds 3'b111.
  assign ready_ext  = {1'b0, out_ready};
  assign held_ready = ready_ext[sel_q];

  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = (state_q == FULL) && held_ready;
  assign legal_in   = in_xfer && (selector != 3'b111);
  assign illegal_in = in_xfer && (selector == 3'b111);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A legal input always refills (covers pass-through
  // while FULL); otherwise a completed delivery empties the register.
  always_comb begin
    state_d = state_q;
    if (legal_in) begin
      state_d = FULL;
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  // Output logic. out_valid decodes straight from state, so an async reset
  // withdraws the offer without waiting for a clock edge.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 7'b0;
    if (state_q == FULL) begin
      in_ready = held_ready;
      for (int i = 0; i < 7; i++) begin
        out_valid[i] = (sel_q == 3'(i));
      end
    end
  end

  // Held value and destination index; data_out keeps its last value after
  // delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q    <= 3'd0;
      data_out <= '0;
    end else if (legal_in) begin
      sel_q    <= selector;
      data_out <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sel <= 1'b0;
    end else if (illegal_in) begin
      err_sel <= 1'b1;
    end
  end

`ifdef DEMUX_DROP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (illegal_in && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux1_7_reg.sv
module tb_demux1_7_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  selector;
  logic [31:0] data_in;
  logic [6:0]  out_valid;
  logic [6:0]  out_ready;
  logic [31:0] data_out;
  logic        err_sel;
`ifdef DEMUX_DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: what the block is holding for whom, plus error tallies.
  bit          m_full;
  int          m_dest;
  logic [31:0] m_data;
  bit          m_err;
  int          m_drops;
  int          m_delivered;

  demux1_7_reg #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .selector  (selector),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err_sel   (err_sel)
`ifdef DEMUX_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full  = 0;
    m_dest  = 0;
    m_data  = 32'h0;
    m_err   = 0;
    m_drops = 0;
  endtask

  // Called 1 time unit after a rising edge. Drives one cycle of inputs,
  // checks outputs against the model just before the next edge, advances
  // the model, and returns 1 time unit after that edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [31:0] d,
                      input logic [6:0] r);
    logic [6:0] exp_ov;
    bit         exp_ir;
    bit         accept;
    bit         deliver;
    in_valid  = v;
    selector  = s;
    data_in   = d;
    out_ready = r;
    #3;
    exp_ov = 7'b0;
    if (m_full) exp_ov = 7'(1 << m_dest);
    exp_ir = !m_full || r[m_dest];
    check("in_ready",  32'(in_ready),  32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("data_out",  data_out,       m_data);
    check("err_sel",   32'(err_sel),   32'(m_err));
`ifdef DEMUX_DROP_COUNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    accept  = v && exp_ir;
    deliver = m_full && r[m_dest];
    if (deliver) m_delivered++;
    if (accept && s != 3'd7) begin
      m_full = 1;
      m_dest = int'(s);
      m_data = d;
    end else if (deliver) begin
      m_full = 0;
    end
    if (accept && s == 3'd7) begin
      m_err = 1;
      if (m_drops < 255) m_drops++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    selector  = 3'd0;
    data_in   = 32'h0;
    out_ready = 7'h00;
    m_delivered = 0;
    model_reset();

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_data_out",  data_out,       32'h0);
    check("rst_err_sel",   32'(err_sel),   32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
`ifdef DEMUX_DROP_COUNT_EN
    check("rst_drop_count", 32'(drop_count), 32'h0);
`endif

    // Single delivery to destination 6
    step(1'b1, 3'd6, 32'hCAFEBABE, 7'h7F);
    check("single_ov",   32'(out_valid), 32'h40);
    check("single_data", data_out,       32'hCAFEBABE);
    step(1'b0, 3'd0, 32'h0, 7'h7F);
    check("single_done", 32'(out_valid), 32'h0);

    // Backpressure on destination 2, next value held by the producer
    step(1'b1, 3'd2, 32'h12345678, 7'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd3, 32'h9, 7'h00);
      check("bp_ov",   32'(out_valid), 32'h04);
      check("bp_data", data_out,       32'h12345678);
    end
    check("bp_in_ready", 32'(in_ready), 32'h0);
    step(1'b1, 3'd3, 32'h9, 7'h04);
    check("bp_next_ov",   32'(out_valid), 32'h08);
    check("bp_next_data", data_out,       32'h9);
    step(1'b0, 3'd0, 32'h0, 7'h7F);

    // Back-to-back sweep across all seven destinations
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 3'(i), 32'h10 + 32'(i), 7'h7F);
      check("sweep_ov",   32'(out_valid), 32'(1) << i);
      check("sweep_data", data_out,       32'h10 + 32'(i));
    end
    step(1'b0, 3'd0, 32'h0, 7'h7F);

    // Illegal selector: dropped, flagged, counted
    step(1'b1, 3'd7, 32'hDEADBEEF, 7'h7F);
    check("illegal_ov",  32'(out_valid), 32'h0);
    check("illegal_err", 32'(err_sel),   32'h1);
`ifdef DEMUX_DROP_COUNT_EN
    check("illegal_cnt1", 32'(drop_count), 32'h1);
`endif
    for (int i = 0; i < 299; i++) begin
      step(1'b1, 3'd7, 32'(i), 7'h7F);
    end
`ifdef DEMUX_DROP_COUNT_EN
    check("illegal_sat", 32'(drop_count), 32'd255);
`endif
    check("illegal_err_sticky", 32'(err_sel), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom(),
           7'($urandom()));
    end
    step(1'b0, 3'd0, 32'h0, 7'h7F);
    if (m_delivered == 0) begin
      checks++;
      errors++;
      $error("FAIL random_deliveries: observed 0 expected nonzero");
    end

    // Async reset while FULL: offer withdrawn before the next edge
    step(1'b1, 3'd4, 32'hA5A5A5A5, 7'h00);
    check("ar_full_ov", 32'(out_valid), 32'h10);
    in_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("ar_ov",       32'(out_valid), 32'h0);
    check("ar_data",     data_out,       32'h0);
    check("ar_in_ready", 32'(in_ready),  32'h1);
    check("ar_err",      32'(err_sel),   32'h0);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd4, 32'h0, 7'h7F);
    end
    check("ar_no_delivery", 32'(out_valid), 32'h0);

    // A few more random cycles after the reset
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
           7'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
